// File: rtl/pc_redirect_ctrl.sv
// Fetch-PC controller: picks sequential, jump, branch or hold each cycle, drives flushes, counts redirects.
// Optional misaligned-target trap is built when PC_ALIGN_TRAP_EN is defined.
module pc_redirect_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      id_inst,
  input  logic             stall,
  input  logic             ex_branch_taken,
  input  logic [31:0]      ex_branch_target,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic [CNT_W-1:0] redirect_cnt,
  output logic             trap,
  output logic [1:0]       state_dbg
);

`ifdef PC_ALIGN_TRAP_EN
  typedef enum logic [1:0] {RUN = 2'd0, FLUSH = 2'd1, TRAP = 2'd2} state_t;
`else
  typedef enum logic [1:0] {RUN = 2'd0, FLUSH = 2'd1} state_t;
`endif

  state_t      state;
  logic        id_jump;
  logic [31:0] jump_target;
  logic        in_trap;
  logic        take_branch;
  logic        take_jump;
  logic        redirect;
  logic [31:0] raw_target;
  logic [31:0] load_target;
  logic [CNT_W-1:0] cnt_next;

  assign id_jump     = (id_inst[31:26] == 6'h02);
  assign jump_target = {{6{id_inst[25]}}, id_inst[25:0]};
  assign pc_plus4    = pc + 32'd4;
  assign state_dbg   = state;

`ifdef PC_ALIGN_TRAP_EN
  assign in_trap = (state == TRAP);
`else
  assign in_trap = 1'b0;
`endif

  // Branch in EX outranks stall and jump; jump is masked in FLUSH because ID holds a squashed slot.
  assign take_branch = !rst && !in_trap && ex_branch_taken;
  assign take_jump   = !rst && !in_trap && !ex_branch_taken && !stall && id_jump && (state == RUN);
  assign redirect    = take_branch || take_jump;
  assign raw_target  = take_branch ? ex_branch_target : jump_target;
  assign load_target = raw_target & ~32'h3;

  assign if_id_flush = redirect;
  assign id_ex_flush = take_branch;

  assign cnt_next = (&redirect_cnt) ? redirect_cnt : redirect_cnt + CNT_W'(1);

`ifdef PC_ALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = (raw_target[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc           <= RESET_PC;
      redirect_cnt <= '0;
      state        <= RUN;
      trap         <= 1'b0;
    end else if (in_trap) begin
      trap <= 1'b1;
    end else if (redirect) begin
      if (misaligned) begin
        state <= TRAP;
        trap  <= 1'b1;
      end else begin
        pc           <= load_target;
        redirect_cnt <= cnt_next;
        state        <= FLUSH;
      end
    end else if (stall) begin
      state <= RUN;
    end else begin
      pc    <= pc_plus4;
      state <= RUN;
    end
  end
`else
  assign trap = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc           <= RESET_PC;
      redirect_cnt <= '0;
      state        <= RUN;
    end else if (redirect) begin
      pc           <= load_target;
      redirect_cnt <= cnt_next;
      state        <= FLUSH;
    end else if (stall) begin
      state <= RUN;
    end else begin
      pc    <= pc_plus4;
      state <= RUN;
    end
  end
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Self-checking bench for pc_redirect_ctrl: directed scenarios plus a random phase,
// a reference model feeding an expected-result queue, and a saturating 2-bit counter instance.
module tb_pc_redirect_ctrl;
  localparam int W = 32 + 32 + 1 + 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] id_inst;
  logic        stall;
  logic        ex_branch_taken;
  logic [31:0] ex_branch_target;
  logic [31:0] pc, pc_plus4, pc_s, pc_plus4_s;
  logic        if_id_flush, id_ex_flush, if_id_flush_s, id_ex_flush_s;
  logic [15:0] redirect_cnt;
  logic [1:0]  redirect_cnt_s;
  logic        trap, trap_s;
  logic [1:0]  state_dbg, state_dbg_s;

  int n_vec = 0;
  int n_err = 0;

  // expected {pc, redirect count (unsaturated), trap, state}
  logic [W-1:0] exp_q[$];

  logic [31:0] m_pc;
  int          m_cnt;
  logic        m_trap;
  logic        m_flush;

  always #5 clk = ~clk;

  pc_redirect_ctrl #(.RESET_PC(32'h0), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_inst(id_inst), .stall(stall),
    .ex_branch_taken(ex_branch_taken), .ex_branch_target(ex_branch_target),
    .pc(pc), .pc_plus4(pc_plus4), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .redirect_cnt(redirect_cnt), .trap(trap), .state_dbg(state_dbg)
  );

  pc_redirect_ctrl #(.RESET_PC(32'h0), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .id_inst(id_inst), .stall(stall),
    .ex_branch_taken(ex_branch_taken), .ex_branch_target(ex_branch_target),
    .pc(pc_s), .pc_plus4(pc_plus4_s), .if_id_flush(if_id_flush_s), .id_ex_flush(id_ex_flush_s),
    .redirect_cnt(redirect_cnt_s), .trap(trap_s), .state_dbg(state_dbg_s)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] jtgt(input logic [31:0] inst);
    if (inst[25]) return 32'hFC00_0000 | {6'b0, inst[25:0]};
    return {6'b0, inst[25:0]};
  endfunction

  task automatic do_reset(input logic [31:0] inst, input logic br);
    rst = 1'b1; id_inst = inst; stall = 1'b1; ex_branch_taken = br; ex_branch_target = 32'h100;
    #1;
    check("rst_if_id_flush", {63'b0, if_id_flush}, 64'd0);
    check("rst_id_ex_flush", {63'b0, id_ex_flush}, 64'd0);
    @(posedge clk); #1;
    m_pc = 32'h0; m_cnt = 0; m_trap = 1'b0; m_flush = 1'b0;
    check("rst_pc", {32'b0, pc}, 64'd0);
    check("rst_cnt", {48'b0, redirect_cnt}, 64'd0);
    check("rst_trap", {63'b0, trap}, 64'd0);
    check("rst_state", {62'b0, state_dbg}, 64'd0);
    rst = 1'b0;
  endtask

  task automatic step(input logic [31:0] inst, input logic stl, input logic br,
                      input logic [31:0] tgt);
    logic        e_f1, e_f2, redir;
    logic [31:0] t;
    logic [1:0]  e_state;
    logic [W-1:0] e;
    int          c2;
    id_inst = inst; stall = stl; ex_branch_taken = br; ex_branch_target = tgt;
    e_f1 = 1'b0; e_f2 = 1'b0; redir = 1'b0; t = 32'h0;
    if (!m_trap) begin
      if (br) begin
        e_f1 = 1'b1; e_f2 = 1'b1; redir = 1'b1; t = tgt;
      end else if (!stl && inst[31:26] == 6'h02 && !m_flush) begin
        e_f1 = 1'b1; redir = 1'b1; t = jtgt(inst);
      end
    end
    #1;
    check("if_id_flush", {63'b0, if_id_flush}, {63'b0, e_f1});
    check("id_ex_flush", {63'b0, id_ex_flush}, {63'b0, e_f2});
    check("pc_plus4", {32'b0, pc_plus4}, {32'b0, m_pc + 32'd4});
    if (m_trap) begin
      // frozen
    end else if (redir) begin
`ifdef PC_ALIGN_TRAP_EN
      if (t[1:0] != 2'b00) m_trap = 1'b1;
      else begin
        m_pc = {t[31:2], 2'b00}; m_cnt++; m_flush = 1'b1;
      end
`else
      m_pc = {t[31:2], 2'b00}; m_cnt++; m_flush = 1'b1;
`endif
    end else begin
      if (!stl) m_pc = m_pc + 32'd4;
      m_flush = 1'b0;
    end
    e_state = m_trap ? 2'd2 : (m_flush ? 2'd1 : 2'd0);
    exp_q.push_back({m_pc, 32'(m_cnt), m_trap, e_state});
    @(posedge clk); #1;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      check("pc", {32'b0, pc}, {32'b0, e[W-1 -: 32]});
      check("redirect_cnt", {48'b0, redirect_cnt},
            (e[34:3] > 32'd65535) ? 64'd65535 : {32'b0, e[34:3]});
      c2 = (e[34:3] > 32'd3) ? 3 : int'(e[34:3]);
      check("redirect_cnt_sat", {62'b0, redirect_cnt_s}, 64'(c2));
      check("trap", {63'b0, trap}, {63'b0, e[2]});
      check("state", {62'b0, state_dbg}, {62'b0, e[1:0]});
    end
  endtask

  localparam logic [31:0] NOP = 32'h0000_0000;

  initial begin
    rst = 1'b1; id_inst = NOP; stall = 1'b0; ex_branch_taken = 1'b0; ex_branch_target = 32'h0;
    m_pc = 32'h0; m_cnt = 0; m_trap = 1'b0; m_flush = 1'b0;
    @(posedge clk);
    do_reset(NOP, 1'b1);

    // free running then jump at pc=8, jump word held through FLUSH is ignored
    repeat (2) step(NOP, 1'b0, 1'b0, 32'h0);
    step(32'h0800_0040, 1'b0, 1'b0, 32'h0);
    step(32'h0800_0040, 1'b0, 1'b0, 32'h0);
    repeat (2) step(NOP, 1'b0, 1'b0, 32'h0);

    // branch beats stall and jump
    step(32'h0800_0040, 1'b1, 1'b1, 32'h0000_0100);
    step(NOP, 1'b0, 1'b0, 32'h0);

    // reach pc=0x20 in RUN, stall 3 cycles with a jump in ID, then take it
    step(NOP, 1'b0, 1'b1, 32'h0000_001C);
    step(NOP, 1'b0, 1'b0, 32'h0);
    repeat (3) step(32'h0800_0200, 1'b1, 1'b0, 32'h0);
    step(32'h0800_0200, 1'b0, 1'b0, 32'h0);
    step(NOP, 1'b0, 1'b0, 32'h0);

    // sign-extended jump target and pc wrap
    step(32'h0BFF_FFFC, 1'b0, 1'b0, 32'h0);
    step(NOP, 1'b0, 1'b0, 32'h0);
    step(NOP, 1'b0, 1'b0, 32'h0);

    // back-to-back branches keep re-entering FLUSH; stall inside FLUSH
    step(NOP, 1'b0, 1'b1, 32'h0000_0400);
    step(NOP, 1'b0, 1'b1, 32'h0000_0800);
    step(32'h0800_0040, 1'b1, 1'b0, 32'h0);
    step(NOP, 1'b0, 1'b0, 32'h0);

    // misaligned branch target
    step(NOP, 1'b0, 1'b1, 32'h0000_0102);
    repeat (3) step(32'h0800_0040, 1'b0, 1'b1, 32'h0000_0200);
    do_reset(NOP, 1'b1);
    step(NOP, 1'b0, 1'b0, 32'h0);

    // random phase
    for (int i = 0; i < 60; i++) begin
      logic [31:0] inst, tgt;
      logic stl, br;
      inst = ($urandom_range(0, 2) == 0) ? {6'h02, 26'($urandom)} : 32'($urandom_range(0, 255));
`ifdef PC_ALIGN_TRAP_EN
      inst[1:0] = 2'b00;
      tgt = {$urandom, 2'b00};
`else
      tgt = $urandom;
`endif
      stl = ($urandom_range(0, 3) == 0);
      br  = ($urandom_range(0, 4) == 0);
      step(inst, stl, br, tgt);
    end

    if (exp_q.size() != 0) check("scoreboard_leftover", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
